// File: rtl/sme_feeder.sv
// sme_feeder: front end of the string-matching engine.
// Collects framed byte records from a valid/ready stream. A string record is
// kept for reuse, and each pattern record starts one match job. A job replays
// the string (only if it changed since the last replay), then the pattern, on
// chardata/isstring/ispattern. The feeder then waits for the engine's
// sme_valid strobe before it accepts the next record.
// Optional build macro SME_FEEDER_WATCHDOG_EN adds a WAIT_RES watchdog and
// the wd_timeout output.
module sme_feeder #(
    parameter int STR_MAX   = 32,
    parameter int PAT_MAX   = 8,
    parameter int WD_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_is_pat,
    input  logic       in_last,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    output logic       busy,
    output logic       err_ovf,
    output logic       err_nostr
`ifdef SME_FEEDER_WATCHDOG_EN
    ,
    output logic       wd_timeout
`endif
);

    localparam int STR_IW = $clog2(STR_MAX);
    localparam int STR_LW = $clog2(STR_MAX + 1);
    localparam int PAT_IW = $clog2(PAT_MAX);
    localparam int PAT_LW = $clog2(PAT_MAX + 1);
    localparam logic [STR_LW-1:0] STR_MAX_L = STR_LW'(STR_MAX);
    localparam logic [STR_LW-1:0] PAT_MAX_L = STR_LW'(PAT_MAX);
    localparam logic [STR_LW-1:0] ONE_L     = STR_LW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT_RES,
        S_GAP
    } state_t;

    state_t            state;
    logic [7:0]        str_buf [STR_MAX];
    logic [7:0]        pat_buf [PAT_MAX];
    logic [STR_LW-1:0] str_len;
    logic [PAT_LW-1:0] pat_len;
    logic [STR_LW-1:0] ld_len;
    logic [STR_LW-1:0] idx;
    logic              str_loaded;
    logic              str_new;
    logic              rec_is_pat;

`ifdef SME_FEEDER_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`endif

    logic              loading;
    logic              accept;
    logic              cur_is_pat;
    logic [STR_LW-1:0] wr_idx;
    logic              room;
    logic              store;
    logic [STR_LW-1:0] cnt_next;
    logic [7:0]        pat_first;

    // Decode the incoming byte: record type, write slot, overflow, and the
    // byte count the record will have once this byte is stored.
    always_comb begin
        loading    = (state == S_IDLE) || (state == S_LOAD);
        accept     = in_valid && in_ready && loading;
        cur_is_pat = (state == S_IDLE) ? in_is_pat : rec_is_pat;
        wr_idx     = (state == S_IDLE) ? '0 : ld_len;
        room       = cur_is_pat ? (wr_idx < PAT_MAX_L) : (wr_idx < STR_MAX_L);
        store      = accept && room;
        cnt_next   = store ? (wr_idx + ONE_L) : wr_idx;
        // A one-byte pattern is still being written to slot 0, so bypass it.
        pat_first  = (state == S_IDLE) ? in_data : pat_buf[0];
    end

    // Record buffers hold data only; they carry no reset.
    always_ff @(posedge clk) begin
        if (store) begin
            if (cur_is_pat) begin
                pat_buf[wr_idx[PAT_IW-1:0]] <= in_data;
            end else begin
                str_buf[wr_idx[STR_IW-1:0]] <= in_data;
            end
        end
    end

    // Control FSM with registered outputs: load records, replay jobs, wait for the engine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            chardata   <= 8'h00;
            isstring   <= 1'b0;
            ispattern  <= 1'b0;
            busy       <= 1'b0;
            err_ovf    <= 1'b0;
            err_nostr  <= 1'b0;
            str_len    <= '0;
            pat_len    <= '0;
            ld_len     <= '0;
            idx        <= '0;
            str_loaded <= 1'b0;
            str_new    <= 1'b0;
            rec_is_pat <= 1'b0;
`ifdef SME_FEEDER_WATCHDOG_EN
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
`endif
        end else begin
            chardata  <= 8'h00;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
`ifdef SME_FEEDER_WATCHDOG_EN
            wd_timeout <= 1'b0;
`endif
            case (state)
                S_IDLE, S_LOAD: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (!room) begin
                            err_ovf <= 1'b1;
                        end
                        if (state == S_IDLE) begin
                            rec_is_pat <= in_is_pat;
                        end
                        ld_len <= cnt_next;
                        if (!in_last) begin
                            state <= S_LOAD;
                        end else if (!cur_is_pat) begin
                            str_len    <= cnt_next;
                            str_loaded <= 1'b1;
                            str_new    <= 1'b1;
                            state      <= S_IDLE;
                        end else if (!str_loaded) begin
                            err_nostr <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            pat_len  <= cnt_next[PAT_LW-1:0];
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            idx      <= ONE_L;
                            if (str_new) begin
                                str_new  <= 1'b0;
                                isstring <= 1'b1;
                                chardata <= str_buf[0];
                                state    <= S_SEND_STR;
                            end else begin
                                ispattern <= 1'b1;
                                chardata  <= pat_first;
                                state     <= S_SEND_PAT;
                            end
                        end
                    end
                end
                S_SEND_STR: begin
                    if (idx == str_len) begin
                        ispattern <= 1'b1;
                        chardata  <= pat_buf[0];
                        idx       <= ONE_L;
                        state     <= S_SEND_PAT;
                    end else begin
                        isstring <= 1'b1;
                        chardata <= str_buf[idx[STR_IW-1:0]];
                        idx      <= idx + ONE_L;
                    end
                end
                S_SEND_PAT: begin
                    if (idx == STR_LW'(pat_len)) begin
                        state <= S_WAIT_RES;
`ifdef SME_FEEDER_WATCHDOG_EN
                        wd_cnt <= '0;
`endif
                    end else begin
                        ispattern <= 1'b1;
                        chardata  <= pat_buf[idx[PAT_IW-1:0]];
                        idx       <= idx + ONE_L;
                    end
                end
                S_WAIT_RES: begin
                    if (sme_valid) begin
                        busy  <= 1'b0;
                        state <= S_GAP;
`ifdef SME_FEEDER_WATCHDOG_EN
                    end else if (wd_cnt == WD_W'(WD_CYCLES - 1)) begin
                        // Engine never answered; force a full resend next job.
                        busy       <= 1'b0;
                        wd_timeout <= 1'b1;
                        str_new    <= 1'b1;
                        state      <= S_GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                S_GAP: begin
                    in_ready <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sme_feeder.md
Name: sme_feeder

Overview:
- Upstream stage of the string-matching engine: accepts framed byte records on a valid/ready stream, buffers them, and replays them on the engine's chardata/isstring/ispattern interface.
- A string record (1–32 bytes) is stored and held for reuse. Each pattern record (1–8 bytes) triggers one match job.
- For each job, the feeder sends the string (only when it is new since the last send), then the pattern, then waits for the engine's valid pulse before accepting the next record.

Parameters:
- STR_MAX, 32, string buffer depth in bytes (index width 5, length width 6).
- PAT_MAX, 8, pattern buffer depth in bytes (index width 3, length width 4).
- WD_CYCLES, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  upstream byte valid
- in_ready  output  1  feeder accepts a byte this cycle
- in_data  input  8  record byte
- in_is_pat  input  1  0 = byte belongs to a string record, 1 = pattern record; held constant within a record
- in_last  input  1  final byte of the record
- chardata  output  8  byte to engine
- isstring  output  1  chardata is a string byte
- ispattern  output  1  chardata is a pattern byte
- sme_valid  input  1  engine result strobe (one-cycle pulse)
- busy  output  1  a job is in flight (SEND_STR, SEND_PAT or WAIT_RES)
- err_ovf  output  1  sticky: a record exceeded its buffer; cleared only by reset
- err_nostr  output  1  sticky: a pattern arrived before any string; cleared only by reset

Behaviour:
- Reset (synchronous): state = IDLE; in_ready = 0; chardata = 0; isstring = 0; ispattern = 0; busy = 0; err_ovf = 0; err_nostr = 0; str_len = 0; pat_len = 0; str_loaded = 0; str_new = 0.
- Reset mid-job drops all buffered data. The engine is reset in parallel on the same reset line.
- All outputs are registered.
- Handshake: a byte transfers when in_valid && in_ready. in_ready = 1 only in IDLE and LOAD.
- IDLE: on the first accepted byte, go to LOAD and store the byte at index 0.
  - If in_last is also set, the record completes in that same cycle.
- LOAD: store each accepted byte at index len and increment len.
  - Bytes beyond STR_MAX / PAT_MAX are accepted but discarded, and err_ovf is set. len saturates at the maximum.
- String record complete: str_len = stored count; str_loaded = 1; str_new = 1; return to IDLE.
- Pattern record complete:
  - If str_loaded = 0: discard the pattern, set err_nostr, return to IDLE.
  - Otherwise: go to SEND_STR if str_new = 1, else go to SEND_PAT.
- The first output byte appears in the cycle after the last record byte is accepted.
- SEND_STR: drive isstring = 1 and chardata = str_buf[k] for k = 0..str_len-1, one byte per cycle, no gaps. Clear str_new. Then go to SEND_PAT.
- SEND_PAT: drive ispattern = 1 and chardata = pat_buf[k] for k = 0..pat_len-1. The first pattern byte immediately follows the last string byte.
  - isstring and ispattern are never both 1.
- WAIT_RES: all strobes are 0 and chardata = 0.
  - On sme_valid = 1, go to GAP. sme_valid in any other state is ignored.
- GAP: one idle cycle with in_ready = 0, then IDLE.
  - The earliest next job's first byte reaches the engine 3 cycles after sme_valid.
- A new string record replaces the stored string completely. A job reuses the last stored string until then.
- Outside SEND_STR and SEND_PAT, chardata = 0.

Optional Feature:
- Macro: SME_FEEDER_WATCHDOG_EN.
- Defined:
  - A counter runs in WAIT_RES. After WD_CYCLES cycles without sme_valid, go to GAP.
  - Pulse output wd_timeout for 1 cycle.
  - Set str_new = 1, so the next job resends the string.
- Undefined: no counter, no wd_timeout port; WAIT_RES waits indefinitely.

Test Plan:
- String "abc" (3 bytes), then pattern "b.": isstring high for 3 cycles with 61,62,63, then ispattern for 2 cycles with 62,2E. Assert sme_valid 5 cycles later -> busy falls, in_ready = 1 two cycles after sme_valid.
- Second pattern "c" with no new string -> only ispattern for 1 cycle with 63; isstring stays 0.
- Pattern "^a" sent right after reset -> no strobes, err_nostr = 1, in_ready returns to 1.
- 34-byte string -> only the first 32 bytes are replayed, err_ovf = 1.
- 10-byte pattern -> 8 bytes replayed, err_ovf = 1.
- Reset asserted during SEND_STR byte 2 -> next cycle all outputs 0 and state IDLE. A following pattern sets err_nostr.
- Watchdog (macro defined, WD_CYCLES = 16): no sme_valid -> wd_timeout pulses on cycle 16 of WAIT_RES; the next pattern resends the full string.
